// File: rtl/result_readout_pkg.sv
// ============================================================
// result_readout_pkg : shared state encodings and display constants
// rev 1.0
// ============================================================
`default_nettype none

package result_readout_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LATCH    = 4'd1,
    ARM      = 4'd2,
    WAIT_G   = 4'd3,
    HELD_G   = 4'd4,
    WAIT_H   = 4'd5,
    HELD_H   = 4'd6,
    COMPLETE = 4'd7,
    DANGER   = 4'hF
  } state_t;

  localparam logic [6:0]  BLANK       = 7'h7F;
  localparam logic [15:0] DANGER_WORD = 16'hDEAD;

  // States in which losing done abandons the readout.
  function automatic logic in_readout(input state_t s);
    return (s == LATCH) || (s == ARM) || (s == WAIT_G) || (s == HELD_G) ||
           (s == WAIT_H) || (s == HELD_H) || (s == COMPLETE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/result_readout_if.sv
// ============================================================
// result_readout_if : compute-side inputs and display outputs
// rev 1.0
// ============================================================
`default_nettype none

interface result_readout_if;
  logic        done;
  logic [15:0] g;
  logic [15:0] h;
  logic        step;
  logic [15:0] disp;
  logic [1:0]  sel;
  logic        complete;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;
  logic [6:0]  HEX3;

  modport master (
    output done, g, h, step,
    input  disp, sel, complete, HEX0, HEX1, HEX2, HEX3
  );

  modport slave (
    input  done, g, h, step,
    output disp, sel, complete, HEX0, HEX1, HEX2, HEX3
  );
endinterface

`default_nettype wire

// File: rtl/result_readout_hex7seg.sv
// ============================================================
// hex7seg : nibble to active-low seven-segment glyph (gfedcba)
// rev 1.0
// ============================================================
`default_nettype none

module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/result_readout.sv
// ============================================================
// result_readout : steps an operator through two latched result words
// rev 1.0
// ============================================================
`default_nettype none

module result_readout
  import result_readout_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              rst,
  result_readout_if.slave   bus
);

  state_t      state_q, state_d;
  logic [15:0] gr_q, gr_d;
  logic [15:0] hr_q, hr_d;

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gr_q    <= 16'h0000;
      hr_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      gr_q    <= gr_d;
      hr_q    <= hr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gr_d    = gr_q;
    hr_d    = hr_q;
    case (state_q)
      IDLE:     if (bus.done) state_d = LATCH;
      LATCH: begin
        gr_d    = bus.g;
        hr_d    = bus.h;
        state_d = bus.step ? ARM : WAIT_G;
      end
      ARM:      if (!bus.step) state_d = WAIT_G;
      WAIT_G:   if (bus.step)  state_d = HELD_G;
      HELD_G:   if (!bus.step) state_d = WAIT_H;
      WAIT_H:   if (bus.step)  state_d = HELD_H;
      HELD_H:   if (!bus.step) state_d = COMPLETE;
      COMPLETE: state_d = COMPLETE;
      DANGER:   state_d = DANGER;
      default:  state_d = DANGER;
    endcase

    // Losing done outranks every step decision, including the capture cycle.
    if (in_readout(state_q) && !bus.done) begin
      state_d = IDLE;
      gr_d    = 16'h0000;
      hr_d    = 16'h0000;
    end
  end

  logic [15:0] disp_w;
  logic [1:0]  sel_w;
  logic        show_digits;

  always_comb begin
    disp_w      = 16'h0000;
    sel_w       = 2'b00;
    show_digits = 1'b1;
    case (state_q)
      IDLE, LATCH, ARM: show_digits = 1'b0;
      WAIT_G, HELD_G: begin
        disp_w = gr_q;
        sel_w  = 2'b01;
      end
      WAIT_H, HELD_H: begin
        disp_w = hr_q;
        sel_w  = 2'b10;
      end
      COMPLETE: begin
        disp_w = hr_q;
        sel_w  = 2'b11;
      end
      default:  disp_w = DANGER_WORD;
    endcase
  end

  logic [6:0] seg_w [4];

  generate
    for (genvar i = 0; i < 4; i++) begin : g_hex
      hex7seg u_hex (
        .nibble (disp_w[4*i +: 4]),
        .seg    (seg_w[i])
      );
    end
  endgenerate

  assign bus.disp     = disp_w;
  assign bus.sel      = sel_w;
  assign bus.complete = (state_q == COMPLETE);
  assign bus.HEX0     = show_digits ? seg_w[0] : BLANK;
  assign bus.HEX1     = show_digits ? seg_w[1] : BLANK;
  assign bus.HEX2     = show_digits ? seg_w[2] : BLANK;
  assign bus.HEX3     = show_digits ? seg_w[3] : BLANK;

endmodule

`default_nettype wire

// File: tb/tb_result_readout.sv
// ============================================================
// tb_result_readout : scoreboard bench for result_readout
// rev 1.0
// ============================================================
`default_nettype none

module tb_result_readout;
  import result_readout_pkg::*;

  typedef struct packed {
    logic [15:0] disp;
    logic [1:0]  sel;
    logic        complete;
    logic [27:0] hex;
  } obs_t;

  logic CLOCK_50 = 1'b0;
  logic rst      = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  result_readout_if bus ();

  result_readout dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;
  obs_t exp_q[$];

  // Reference model: a capture session plus a count of step edges consumed.
  logic        m_busy, m_fresh, m_armed, m_danger;
  int          m_edges;
  logic [15:0] m_gr, m_hr;

  string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] s = 7'h7F;
    string str = lit[n];
    for (int i = 0; i < str.len(); i++) s[str[i] - "a"] = 1'b0;
    return s;
  endfunction

  function automatic logic [27:0] digits(input logic [15:0] v);
    return {glyph(v[15:12]), glyph(v[11:8]), glyph(v[7:4]), glyph(v[3:0])};
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o = '{disp: 16'h0, sel: 2'b00, complete: 1'b0, hex: {4{7'h7F}}};
    if (m_danger) begin
      o.disp = 16'hDEAD;
      o.hex  = digits(16'hDEAD);
    end else if (m_busy && !m_fresh && !m_armed) begin
      o.disp     = (m_edges < 2) ? m_gr : m_hr;
      o.sel      = (m_edges < 2) ? 2'b01 : (m_edges < 4) ? 2'b10 : 2'b11;
      o.complete = (m_edges == 4);
      o.hex      = digits(o.disp);
    end
    return o;
  endfunction

  task automatic model_update(input logic inj);
    if (!rst) begin
      m_busy = 0; m_fresh = 0; m_armed = 0; m_danger = 0; m_edges = 0;
      m_gr = 0; m_hr = 0;
    end else if (inj) begin
      m_danger = 1;
    end else if (m_danger) begin
      m_danger = 1;
    end else if (!m_busy) begin
      if (bus.done) begin
        m_busy = 1; m_fresh = 1; m_armed = 0; m_edges = 0;
      end
    end else if (!bus.done) begin
      m_busy = 0; m_gr = 0; m_hr = 0;
    end else if (m_fresh) begin
      m_fresh = 0; m_armed = bus.step; m_gr = bus.g; m_hr = bus.h;
    end else if (m_armed) begin
      if (!bus.step) m_armed = 0;
    end else if (m_edges < 4 && bus.step == (m_edges % 2 == 0)) begin
      m_edges++;
    end
  endtask

  function automatic obs_t sample();
    return '{disp: bus.disp, sel: bus.sel, complete: bus.complete,
             hex: {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}};
  endfunction

  task automatic compare(input string name, input obs_t act, input obs_t e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s t=%0t: got disp=%h sel=%b cmp=%b hex=%h, want disp=%h sel=%b cmp=%b hex=%h",
               name, $time, act.disp, act.sel, act.complete, act.hex,
               e.disp, e.sel, e.complete, e.hex);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, push what the next rising edge must show.
  task automatic tick(input logic d, input logic s, input logic [15:0] gg, input logic [15:0] hh,
                      input logic r = 1'b1, input logic inj = 1'b0);
    logic prev_r;
    @(negedge CLOCK_50);
    if (inj) begin
      force dut.state_q = state_t'(4'hA);
      #1;
      release dut.state_q;
    end
    prev_r   = rst;
    bus.done = d;
    bus.step = s;
    bus.g    = gg;
    bus.h    = hh;
    rst      = r;
    model_update(inj);
    if (prev_r && !r) begin
      #1;
      compare("async_reset", sample(), model_out());
    end
    exp_q.push_back(model_out());
  endtask

  always @(posedge CLOCK_50) begin
    #1;
    if (exp_q.size() > 0) compare("outputs", sample(), exp_q.pop_front());
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic st;
    bus.done = 0; bus.step = 0; bus.g = 0; bus.h = 0;
    m_busy = 0; m_fresh = 0; m_armed = 0; m_danger = 0; m_edges = 0; m_gr = 0; m_hr = 0;

    repeat (3) tick(0, 0, 16'h0, 16'h0, 1'b0);
    repeat (2) tick(0, 0, 16'h0, 16'h0);

    // Nominal readout, with g changing after capture.
    repeat (2) tick(1, 0, 16'h1234, 16'hABCD);
    repeat (2) tick(1, 1, 16'hFFFF, 16'hABCD);
    repeat (2) tick(1, 0, 16'hFFFF, 16'hABCD);
    repeat (2) tick(1, 1, 16'hFFFF, 16'h0000);
    repeat (3) tick(1, 0, 16'h5555, 16'h0000);
    tick(0, 0, 16'h5555, 16'h0000);
    tick(0, 0, 16'h5555, 16'h0000);

    // Step already high at capture.
    repeat (4) tick(1, 1, 16'h0F0F, 16'h9876);
    repeat (3) tick(1, 0, 16'h0F0F, 16'h9876);

    // Advance to WAIT_H then drop done.
    tick(1, 1, 16'h0, 16'h0);
    tick(1, 0, 16'h0, 16'h0);
    tick(0, 0, 16'h0, 16'h0);
    repeat (2) tick(0, 0, 16'h0, 16'h0);

    // Reset in HELD_G, then recapture.
    repeat (2) tick(1, 0, 16'hC0DE, 16'hBEEF);
    tick(1, 1, 16'hC0DE, 16'hBEEF);
    tick(1, 1, 16'hC0DE, 16'hBEEF, 1'b0);
    tick(1, 1, 16'hC0DE, 16'hBEEF, 1'b0);
    repeat (3) tick(1, 0, 16'h4321, 16'h8765);
    repeat (2) tick(1, 1, 16'h4321, 16'h8765);
    repeat (2) tick(1, 0, 16'h4321, 16'h8765);

    // Illegal state value, held through stimulus until reset.
    tick(1, 0, 16'h1, 16'h2, 1'b1, 1'b1);
    repeat (4) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    tick(0, 0, 16'h0, 16'h0, 1'b0);
    tick(0, 0, 16'h0, 16'h0);

    // Randomized operation.
    st = 0;
    for (int i = 0; i < 2500; i++) begin
      logic d;
      if ($urandom_range(0, 9) < 3) st = ~st;
      d = (m_busy && m_edges == 4) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 39) != 0);
      if (!m_busy && $urandom_range(0, 3) == 0) d = 0;
      tick(d, st, 16'($urandom), 16'($urandom), ($urandom_range(0, 299) != 0));
    end

    repeat (3) @(negedge CLOCK_50);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d queued, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
